// File: rtl/cr_tlvp_merge_pkg.sv
// Shared types and constants for the N-channel TLV merge block.
package cr_tlvp_merge_pkg;

  localparam int TLVP_DATA_W = 64;

  localparam int ERR_OVF   = 0;
  localparam int ERR_PROTO = 1;
  localparam int ERR_LEN   = 2;
  localparam int ERR_W     = 3;

  typedef struct packed {
    logic [TLVP_DATA_W-1:0] data;
    logic                   sot;
    logic                   eot;
  } tlvp_merge_word_t;

  // Channel-ID width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_tlvp_merge_fifo.sv
// Synchronous FIFO, head visible combinationally, all status flags registered.
// A write while full is accepted only when a pop happens in the same cycle.
module cr_tlvp_merge_fifo #(
  parameter int W          = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_VAL  = 2,
  parameter int AEMPTY_VAL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         afull,
  output logic         empty,
  output logic         aempty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d, afull_q, afull_d;
  logic          empty_q, empty_d, aempty_q, aempty_d;
  logic          wr_en, rd_en;

  always_comb begin
    rd_en    = rd && !empty_q;
    wr_en    = wr && (!full_q || rd_en);
    wptr_d   = wr_en ? wptr_q + AW'(1) : wptr_q;
    rptr_d   = rd_en ? rptr_q + AW'(1) : rptr_q;
    cnt_d    = cnt_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    full_d   = (cnt_d == (AW+1)'(DEPTH));
    afull_d  = (((AW+1)'(DEPTH) - cnt_d) <= (AW+1)'(AFULL_VAL));
    empty_d  = (cnt_d == '0);
    aempty_d = (cnt_d <= (AW+1)'(AEMPTY_VAL));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wdata;
  end

  // Storage is not reset, so the head reads as zero whenever nothing is queued.
  assign rdata  = empty_q ? '0 : mem_q[rptr_q];
  assign full   = full_q;
  assign afull  = afull_q;
  assign empty  = empty_q;
  assign aempty = aempty_q;

endmodule

// File: rtl/cr_tlvp_merge.sv
// Merges N_CH TLV streams into one, whole TLVs at a time, tagging each word with its channel.
// Write-to-visible latency is two cycles; transfers stall only when the output FIFO is full and not popped.
module cr_tlvp_merge
  import cr_tlvp_merge_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int DATA_W         = TLVP_DATA_W,
  parameter int IN_DEPTH       = 16,
  parameter int IN_AFULL_VAL   = 2,
  parameter int OUT_DEPTH      = 16,
  parameter int OUT_AEMPTY_VAL = 1,
  parameter int MAX_FRAME      = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          in_wr,
  input  logic [N_CH*DATA_W-1:0]   in_data,
  input  logic [N_CH-1:0]          in_sot,
  input  logic [N_CH-1:0]          in_eot,
  output logic [N_CH-1:0]          in_full,
  output logic [N_CH-1:0]          in_afull,
  input  logic                     rr_mode,
  input  logic                     ob_rd,
  output logic                     ob_empty,
  output logic                     ob_aempty,
  output logic [DATA_W-1:0]        ob_data,
  output logic                     ob_sot,
  output logic                     ob_eot,
  output logic [ch_w(N_CH)-1:0]    ob_ch,
  output logic                     err_pulse,
  output logic [ERR_W*N_CH-1:0]    err_sticky
);

  localparam int CH_W   = ch_w(N_CH);
  localparam int WORD_W = $bits(tlvp_merge_word_t);
  localparam int OUT_W  = CH_W + WORD_W;
  localparam int FC_W   = $clog2(MAX_FRAME + 2);

  typedef enum logic {ST_IDLE, ST_LOCK} state_e;

  state_e                   state_q, state_d;
  logic [CH_W-1:0]          lock_ch_q, lock_ch_d;
  logic                     lock_rr_q, lock_rr_d;
  logic [CH_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [FC_W-1:0]          fcnt_q, fcnt_d;
  logic [ERR_W*N_CH-1:0]    err_sticky_q, err_sticky_d, err_set;
  logic                     err_pulse_q, err_pulse_d;

  tlvp_merge_word_t         hd [N_CH];
  logic [N_CH-1:0]          in_empty, elig, pop;
  logic [CH_W-1:0]          base, gnt_ch, disc_ch, xfer_ch;
  logic                     gnt_vld, disc_vld, xfer, out_ok;

  logic [OUT_W-1:0]         ob_wdata, ob_rdata;
  logic                     ob_full, ob_afull_unused;
  tlvp_merge_word_t         ob_word;

  for (genvar i = 0; i < N_CH; i++) begin : g_in
    tlvp_merge_word_t wr_word;
    logic             aempty_unused;

    assign wr_word = '{data: in_data[i*DATA_W +: DATA_W], sot: in_sot[i], eot: in_eot[i]};

    cr_tlvp_merge_fifo #(
      .W(WORD_W), .DEPTH(IN_DEPTH), .AFULL_VAL(IN_AFULL_VAL), .AEMPTY_VAL(1)
    ) u_in_fifo (
      .clk(clk), .rst(rst), .wr(in_wr[i]), .wdata(wr_word), .rd(pop[i]),
      .rdata(hd[i]), .full(in_full[i]), .afull(in_afull[i]),
      .empty(in_empty[i]), .aempty(aempty_unused)
    );
  end

  always_comb begin
    state_d  = state_q;
    lock_ch_d = lock_ch_q;
    lock_rr_d = lock_rr_q;
    rr_ptr_d = rr_ptr_q;
    fcnt_d   = fcnt_q;
    xfer     = 1'b0;
    xfer_ch  = lock_ch_q;
    pop      = '0;
    err_set  = '0;
    gnt_vld  = 1'b0;
    gnt_ch   = '0;
    disc_vld = 1'b0;
    disc_ch  = '0;
    out_ok   = !ob_full || ob_rd;
    base     = rr_mode ? rr_ptr_q : '0;

    for (int i = 0; i < N_CH; i++) elig[i] = !in_empty[i] && hd[i].sot;

    // Cyclic search from base; base is zero in priority mode.
    for (int k = 0; k < N_CH; k++) begin
      if (!gnt_vld && elig[(int'(base) + k) % N_CH]) begin
        gnt_vld = 1'b1;
        gnt_ch  = CH_W'((int'(base) + k) % N_CH);
      end
    end

    for (int i = N_CH-1; i >= 0; i--) begin
      if (!in_empty[i] && !hd[i].sot) begin
        disc_vld = 1'b1;
        disc_ch  = CH_W'(i);
      end
    end

    if (state_q == ST_IDLE) begin
      if (gnt_vld && out_ok) begin
        xfer    = 1'b1;
        xfer_ch = gnt_ch;
        fcnt_d  = FC_W'(1);
        if (hd[gnt_ch].eot) begin
          if (rr_mode) rr_ptr_d = (gnt_ch == CH_W'(N_CH-1)) ? '0 : gnt_ch + CH_W'(1);
        end else begin
          state_d   = ST_LOCK;
          lock_ch_d = gnt_ch;
          lock_rr_d = rr_mode;
        end
      end else if (disc_vld) begin
        pop[disc_ch] = 1'b1;
        err_set[int'(disc_ch)*ERR_W + ERR_PROTO] = 1'b1;
      end
    end else if (!in_empty[lock_ch_q] && out_ok) begin
      xfer = 1'b1;
      // Counter saturates so an oversized frame flags its length error once.
      if (fcnt_q != FC_W'(MAX_FRAME + 1)) fcnt_d = fcnt_q + FC_W'(1);
      if (fcnt_q == FC_W'(MAX_FRAME)) err_set[int'(lock_ch_q)*ERR_W + ERR_LEN] = 1'b1;
      if (hd[lock_ch_q].sot) err_set[int'(lock_ch_q)*ERR_W + ERR_PROTO] = 1'b1;
      if (hd[lock_ch_q].eot) begin
        state_d = ST_IDLE;
        if (lock_rr_q) rr_ptr_d = (lock_ch_q == CH_W'(N_CH-1)) ? '0 : lock_ch_q + CH_W'(1);
      end
    end

    if (xfer) pop[xfer_ch] = 1'b1;

    for (int i = 0; i < N_CH; i++) begin
      if (in_wr[i] && in_full[i] && !pop[i]) err_set[i*ERR_W + ERR_OVF] = 1'b1;
    end

    err_sticky_d = err_sticky_q | err_set;
    err_pulse_d  = |(err_set & ~err_sticky_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      lock_ch_q    <= '0;
      lock_rr_q    <= 1'b0;
      rr_ptr_q     <= '0;
      fcnt_q       <= '0;
      err_sticky_q <= '0;
      err_pulse_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_ch_q    <= lock_ch_d;
      lock_rr_q    <= lock_rr_d;
      rr_ptr_q     <= rr_ptr_d;
      fcnt_q       <= fcnt_d;
      err_sticky_q <= err_sticky_d;
      err_pulse_q  <= err_pulse_d;
    end
  end

  assign ob_wdata = {xfer_ch, hd[xfer_ch]};

  cr_tlvp_merge_fifo #(
    .W(OUT_W), .DEPTH(OUT_DEPTH), .AFULL_VAL(1), .AEMPTY_VAL(OUT_AEMPTY_VAL)
  ) u_out_fifo (
    .clk(clk), .rst(rst), .wr(xfer), .wdata(ob_wdata), .rd(ob_rd),
    .rdata(ob_rdata), .full(ob_full), .afull(ob_afull_unused),
    .empty(ob_empty), .aempty(ob_aempty)
  );

  assign ob_word    = ob_rdata[WORD_W-1:0];
  assign ob_ch      = ob_rdata[OUT_W-1 -: CH_W];
  assign ob_data    = ob_word.data;
  assign ob_sot     = ob_word.sot;
  assign ob_eot     = ob_word.eot;
  assign err_pulse  = err_pulse_q;
  assign err_sticky = err_sticky_q;

endmodule
